// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Single-outstanding instruction fetcher feeding a DEPTH-entry queue
// Revision : 1.0  initial release
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ireq_valid,
    output logic [63:0]                  ireq_addr,
    input  logic                         iresp_data_ok,
    input  logic [31:0]                  iresp_data,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         out_valid,
    output logic [63:0]                  out_pc,
    output logic [31:0]                  out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [63:0]   r_req_pc;
    logic [63:0]   w_req_pc_nxt;
    logic [63:0]   r_pending_pc;
    logic [63:0]   w_pending_pc_nxt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_after;
    logic          w_push;
    logic          w_pop;

    logic [63:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    // A response is only accepted in REQ; a redirect on the same cycle kills it.
    assign w_push        = (r_state == S_REQ) && iresp_data_ok && !redirect_valid;
    assign out_valid     = (r_count != '0) && !redirect_valid;
    assign w_pop         = out_valid && out_ready;
    assign w_count_after = r_count + CW'(w_push) - CW'(w_pop);

    assign ireq_valid = (r_state != S_IDLE);
    assign ireq_addr  = r_req_pc;
    assign out_pc     = r_pc_mem[r_rptr];
    assign out_instr  = r_instr_mem[r_rptr];
    assign count      = r_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_req_pc_nxt     = r_req_pc;
        w_pending_pc_nxt = r_pending_pc;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_req_pc_nxt = redirect_pc;
                    w_state_nxt  = S_REQ;
                end else if (r_count < C_DEPTH) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        w_req_pc_nxt = redirect_pc;
                    end else begin
                        // Old request is still in flight: keep its address on the bus.
                        w_pending_pc_nxt = redirect_pc;
                        w_state_nxt      = S_DISCARD;
                    end
                end else if (iresp_data_ok) begin
                    w_req_pc_nxt = r_req_pc + 64'd4;
                    w_state_nxt  = (w_count_after < C_DEPTH) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (iresp_data_ok) begin
                    w_req_pc_nxt = redirect_valid ? redirect_pc : r_pending_pc;
                    w_state_nxt  = S_REQ;
                end else if (redirect_valid) begin
                    w_pending_pc_nxt = redirect_pc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_req_pc     <= RESET_PC;
            r_pending_pc <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_req_pc     <= w_req_pc_nxt;
            r_pending_pc <= w_pending_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= r_req_pc;
            r_instr_mem[r_wptr] <= iresp_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set instruction-queue entries; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 64'h8000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 ireq_valid  output  1  instruction-bus request valid.
REQ-006 ireq_addr  output  64  instruction-bus request address.
REQ-007 iresp_data_ok  input  1  response valid; completes the outstanding request.
REQ-008 iresp_data  input  32  fetched instruction, valid with iresp_data_ok.
REQ-009 redirect_valid  input  1  control-flow redirect/flush.
REQ-010 redirect_pc  input  64  new fetch address, sampled with redirect_valid.
REQ-011 out_valid  output  1  queue head holds an instruction for decode.
REQ-012 out_pc  output  64  PC of the head entry.
REQ-013 out_instr  output  32  raw instruction of the head entry.
REQ-014 out_ready  input  1  decode accepts the head; pop occurs when out_valid and out_ready are both 1.
REQ-015 count  output  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-016 The block SHALL implement states IDLE, REQ, DISCARD; ireq_valid SHALL be 1 exactly in REQ and DISCARD.
REQ-017 The block SHALL drive ireq_addr from the registered req_pc, holding it stable from request issue through the cycle of iresp_data_ok inclusive; there SHALL be at most one outstanding request.
REQ-018 IDLE->REQ SHALL occur when count plus pending pushes < DEPTH; the slot is reserved, so a response always has room.
REQ-019 In REQ with iresp_data_ok=1 and no redirect, the block SHALL push {req_pc, iresp_data}, set req_pc to req_pc+4 (64-bit wrap), and stay in REQ if a further slot is free after this push and any same-cycle pop, else go to IDLE.
REQ-020 In REQ with iresp_data_ok=0 and no redirect, the block SHALL hold state and req_pc.
REQ-021 On redirect_valid=1, the queue SHALL flush (count=0 next cycle), and any same-cycle iresp_data SHALL be dropped.
REQ-022 Redirect in IDLE, or in REQ coincident with iresp_data_ok=1, SHALL load req_pc=redirect_pc and go to REQ.
REQ-023 Redirect in REQ with iresp_data_ok=0 SHALL save redirect_pc into pending_pc and go to DISCARD, keeping the old ireq_addr on the bus.
REQ-024 In DISCARD the block SHALL drop the response at iresp_data_ok=1, then load req_pc=pending_pc and go to REQ.
REQ-025 A further redirect in DISCARD SHALL overwrite pending_pc, with last redirect wins; if coincident with iresp_data_ok, the new redirect_pc SHALL be used.
REQ-026 out_valid SHALL equal (count != 0) and not redirect_valid; out_pc/out_instr SHALL be the head entry, combinational from storage.
REQ-027 Push-to-visibility latency SHALL be 1 cycle, with no bypass: data_ok at edge N gives out_valid at N+1.
REQ-028 A push and a pop in the same cycle SHALL leave count unchanged; a pop with the queue empty SHALL have no effect.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-030 A pop coincident with redirect SHALL be ignored, since the flush takes priority.

Reset
REQ-031 While reset=0, the block SHALL hold state=IDLE, req_pc=RESET_PC, pending_pc=RESET_PC, pointers=0, count=0, ireq_valid=0, out_valid=0, regardless of clk.
REQ-032 Asserting reset mid-request SHALL abandon the outstanding request; after release, the first rising edge SHALL enter REQ at RESET_PC.

Verification
REQ-033 Release reset, data_ok each cycle, out_ready=0, DEPTH=4 -> addresses 8000_0000, _0004, _0008, _000C fetched; count=4; ireq_valid=0; IDLE held.
REQ-034 Streaming with data_ok every cycle and out_ready=1 -> out_pc advances by 4 every cycle; count stays at 1 in steady state.
REQ-035 Redirect to 8000_1000 while REQ waits (data_ok late by 3 cycles) -> ireq_addr unchanged until data_ok, that data dropped, next ireq_addr=8000_1000, first out_pc=8000_1000.
REQ-036 Redirects to 8000_2000 then 8000_3000 during DISCARD -> only 8000_3000 fetched, and no stale entry appears at the output.
REQ-037 Redirect coincident with data_ok and out_ready=1 with count=2 -> next cycle count=0, out_valid=0, ireq_addr=redirect_pc.
REQ-038 Reset pulse while count=3 and a request is outstanding -> count=0, out_valid=0 immediately; refetch resumes at 8000_0000.
